// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor. The carry chain is cut into nrOfStages equal
// slices; slice k is added in stage k using the carry registered by stage k-1.
// Operand bits not yet consumed ride along with each stage, and finished sum
// slices accumulate, so a whole result leaves the last stage in one cycle.
module pipelined_adder #(
   parameter int unsigned nrOfBits   = 16,
   parameter int unsigned nrOfStages = 2
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                inValid,
   output logic                inReady,
   input  logic [nrOfBits-1:0] dataA,
   input  logic [nrOfBits-1:0] dataB,
   input  logic                carryIn,
   input  logic                subtract,
   output logic                outValid,
   input  logic                outReady,
   output logic [nrOfBits-1:0] result,
   output logic                carryOut,
   output logic                overflow,
   output logic                zero
);

   localparam int unsigned sliceWidth = nrOfBits / nrOfStages;
   localparam int unsigned lastStage  = nrOfStages - 1;

   logic                stall;
   logic [nrOfBits-1:0] bEff;

   assign bEff    = subtract ? ~dataB : dataB;
   assign stall   = outValid && !outReady;
   assign inReady = !stall;

   genvar k;
   generate
      for (k = 0; k < nrOfStages; k++) begin : gStage
         // Operand bits still unconsumed at this stage's input; the LSB slice is added here.
         localparam int unsigned inW  = nrOfBits - k * sliceWidth;
         localparam int unsigned sumW = (k + 1) * sliceWidth;

         logic [inW-1:0]        aIn;
         logic [inW-1:0]        bIn;
         logic                  cIn;
         logic                  vIn;
         logic [sliceWidth:0]   sliceSum;
         logic [sumW-1:0]       sumD;
         logic                  validQ;
         logic                  carryQ;
         logic [sumW-1:0]       sumQ;

         if (k == 0) begin : gFirst
            assign aIn  = dataA;
            assign bIn  = bEff;
            assign cIn  = carryIn;
            assign vIn  = inValid;
            assign sumD = sliceSum[sliceWidth-1:0];
         end else begin : gNext
            assign aIn  = gStage[k-1].gRem.aQ;
            assign bIn  = gStage[k-1].gRem.bQ;
            assign cIn  = gStage[k-1].carryQ;
            assign vIn  = gStage[k-1].validQ;
            assign sumD = {sliceSum[sliceWidth-1:0], gStage[k-1].sumQ};
         end

         assign sliceSum = {1'b0, aIn[sliceWidth-1:0]} + {1'b0, bIn[sliceWidth-1:0]}
                         + {{sliceWidth{1'b0}}, cIn};

         // Valid bit, slice carry and accumulated sum advance together unless stalled.
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               validQ <= 1'b0;
               carryQ <= 1'b0;
               sumQ   <= '0;
            end else if (!stall) begin
               validQ <= vIn;
               carryQ <= sliceSum[sliceWidth];
               sumQ   <= sumD;
            end
         end

         if (k < lastStage) begin : gRem
            logic [inW-sliceWidth-1:0] aQ;
            logic [inW-sliceWidth-1:0] bQ;

            // Skew the upper operand slices for the stages that still need them.
            always_ff @(posedge clock or negedge reset_n) begin
               if (!reset_n) begin
                  aQ <= '0;
                  bQ <= '0;
               end else if (!stall) begin
                  aQ <= aIn[inW-1:sliceWidth];
                  bQ <= bIn[inW-1:sliceWidth];
               end
            end
         end else begin : gLast
            logic overflowQ;
            logic zeroQ;

            // Flags need the full result and the operand MSBs, all known at this stage.
            always_ff @(posedge clock or negedge reset_n) begin
               if (!reset_n) begin
                  overflowQ <= 1'b0;
                  zeroQ     <= 1'b0;
               end else if (!stall) begin
                  overflowQ <= (aIn[inW-1] == bIn[inW-1])
                            && (sliceSum[sliceWidth-1] != aIn[inW-1]);
                  zeroQ     <= (sumD == '0);
               end
            end
         end
      end
   endgenerate

   assign outValid = gStage[lastStage].validQ;
   assign result   = gStage[lastStage].sumQ;
   assign carryOut = gStage[lastStage].carryQ;
   assign overflow = gStage[lastStage].gLast.overflowQ;
   // A bubble can carry a zero sum; report zero only for real results.
   assign zero     = outValid && gStage[lastStage].gLast.zeroQ;

endmodule
